// File: rtl/hdmi_fmt_pkg.sv
// rtl/hdmi_fmt_pkg.sv - shared constants, types and helpers for the HDMI 4:2:2 formatter
package hdmi_fmt_pkg;

  localparam int LATENCY = 5;
  localparam int SHIFT   = 8;

  localparam logic signed [17:0] ROUND = 18'sd128;

  // BT.709 limited-range coefficients scaled by 256
  localparam logic signed [17:0] K_YR  =  18'sd47;
  localparam logic signed [17:0] K_YG  =  18'sd157;
  localparam logic signed [17:0] K_YB  =  18'sd16;
  localparam logic signed [17:0] K_CBR = -18'sd26;
  localparam logic signed [17:0] K_CBG = -18'sd86;
  localparam logic signed [17:0] K_CBB =  18'sd112;
  localparam logic signed [17:0] K_CRR =  18'sd112;
  localparam logic signed [17:0] K_CRG = -18'sd102;
  localparam logic signed [17:0] K_CRB = -18'sd10;

  localparam logic signed [11:0] Y_OFF = 12'sd16;
  localparam logic signed [11:0] C_OFF = 12'sd128;

  localparam logic signed [11:0] Y_MIN    = 12'sd16;
  localparam logic signed [11:0] Y_MAX    = 12'sd235;
  localparam logic signed [11:0] C_MIN    = 12'sd16;
  localparam logic signed [11:0] C_MAX    = 12'sd240;
  localparam logic signed [11:0] FULL_MIN = 12'sd1;
  localparam logic signed [11:0] FULL_MAX = 12'sd254;

  localparam logic [15:0] BLANK_DATA = 16'h8010;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  function automatic logic [7:0] clamp8(input logic signed [11:0] v,
                                        input logic signed [11:0] lo,
                                        input logic signed [11:0] hi);
    logic signed [11:0] t;
    t = v;
    if (v < lo) t = lo;
    else if (v > hi) t = hi;
    return t[7:0];
  endfunction

  // rounded mean of two 8-bit samples
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/hdmi_csc_709.sv
// rtl/hdmi_csc_709.sv - 3-stage BT.709 RGB->YCbCr converter with registered bypass
import hdmi_fmt_pkg::*;

module hdmi_csc_709 #(
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_in,
  input  logic        bypass_in,
  output ycc_t        ycc_out
);

  localparam logic signed [17:0] COEF [9] = '{K_YR, K_YG, K_YB,
                                              K_CBR, K_CBG, K_CBB,
                                              K_CRR, K_CRG, K_CRB};

  localparam logic signed [11:0] YLO = CLAMP_EN ? Y_MIN : FULL_MIN;
  localparam logic signed [11:0] YHI = CLAMP_EN ? Y_MAX : FULL_MAX;
  localparam logic signed [11:0] CLO = CLAMP_EN ? C_MIN : FULL_MIN;
  localparam logic signed [11:0] CHI = CLAMP_EN ? C_MAX : FULL_MAX;

  logic signed [17:0] chan   [3];
  logic signed [17:0] prod_c [9];
  logic signed [17:0] prod_q [9];
  logic signed [17:0] acc    [3];
  logic signed [17:0] sh     [3];
  logic signed [11:0] sum_q  [3];
  logic signed [11:0] pre    [3];
  logic [23:0]        raw1, raw2;
  logic               byp1, byp2;

  // widen R,G,B and form all nine coefficient products
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      chan[k] = {10'd0, pix_in[8*(2-k) +: 8]};
    end
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 3; k++) begin
        prod_c[3*c+k] = chan[k] * COEF[3*c+k];
      end
    end
  end

  // stage 1: register products, carry raw pixel for bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '{default: '0};
      raw1   <= '0;
      byp1   <= 1'b0;
    end else begin
      prod_q <= prod_c;
      raw1   <= pix_in;
      byp1   <= bypass_in;
    end
  end

  // sum each row with rounding, then arithmetic scale-down
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      acc[c] = prod_q[3*c] + prod_q[3*c+1] + prod_q[3*c+2] + ROUND;
      sh[c]  = acc[c] >>> SHIFT;
    end
  end

  // stage 2: register scaled sums
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '{default: '0};
      raw2  <= '0;
      byp2  <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) sum_q[c] <= sh[c][11:0];
      raw2 <= raw1;
      byp2 <= byp1;
    end
  end

  // add offsets, or pick the raw YCbCr sample in bypass
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pre[c] = byp2 ? $signed({4'd0, raw2[8*(2-c) +: 8]})
                    : sum_q[c] + ((c == 0) ? Y_OFF : C_OFF);
    end
  end

  // stage 3: clamp to legal range and register
  always_ff @(posedge clk) begin
    if (rst) begin
      ycc_out <= '0;
    end else begin
      ycc_out.y  <= clamp8(pre[0], YLO, YHI);
      ycc_out.cb <= clamp8(pre[1], CLO, CHI);
      ycc_out.cr <= clamp8(pre[2], CLO, CHI);
    end
  end

endmodule

// File: rtl/hdmi_422_formatter.sv
// rtl/hdmi_422_formatter.sv - 4:4:4 to 16-bit YCbCr 4:2:2 formatter for the ADV7511
import hdmi_fmt_pkg::*;

module hdmi_422_formatter #(
  parameter bit AVG_CHROMA = 1'b1,
  parameter bit CLAMP_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [23:0] in_pix,
  input  logic        mode,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [15:0] out_data
);

  // delay taps before the output register; the CSC output lines up with tap DL-2
  localparam int DL = LATENCY - 1;

  logic          de_prev, vs_prev, odd_next, mode_q;
  logic          cur_odd;
  logic [DL-1:0] de_d, hs_d, vs_d, odd_d;
  ycc_t          csc_q;
  logic [7:0]    y4, cb4, cr4, pend_c, c_even;
  logic [15:0]   data_c;

  hdmi_csc_709 #(.CLAMP_EN(CLAMP_EN)) u_csc (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (in_pix),
    .bypass_in (mode_q),
    .ycc_out   (csc_q)
  );

  // a pixel is odd only if DE was already high on the previous clock
  assign cur_odd = de_prev & odd_next;

  // input-side phase tracking and per-frame mode latch
  always_ff @(posedge clk) begin
    if (rst) begin
      de_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      odd_next <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      de_prev  <= in_de;
      vs_prev  <= in_vs;
      odd_next <= in_de & ~cur_odd;
      if (in_vs && !vs_prev) mode_q <= mode;
    end
  end

  // control/sync delay line matching the CSC pipe plus the look-ahead stage
  always_ff @(posedge clk) begin
    if (rst) begin
      de_d  <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      odd_d <= '0;
    end else begin
      de_d  <= {de_d[DL-2:0], in_de};
      hs_d  <= {hs_d[DL-2:0], in_hs};
      vs_d  <= {vs_d[DL-2:0], in_vs};
      odd_d <= {odd_d[DL-2:0], in_de & cur_odd};
    end
  end

  // look-ahead stage: hold pixel k while pixel k+1 sits at the CSC output;
  // an even pixel also prepares the Cr its odd partner will send
  always_ff @(posedge clk) begin
    if (rst) begin
      y4     <= '0;
      cb4    <= '0;
      cr4    <= '0;
      pend_c <= '0;
    end else begin
      y4  <= csc_q.y;
      cb4 <= csc_q.cb;
      cr4 <= csc_q.cr;
      if (de_d[DL-1] && !odd_d[DL-1]) begin
        pend_c <= AVG_CHROMA ? avg8(cr4, csc_q.cr) : cr4;
      end
    end
  end

  // output mux: even -> Cb (paired if a partner follows), odd -> prepared Cr, blank when DE low
  always_comb begin
    c_even = cb4;
    if (AVG_CHROMA && de_d[DL-2] && odd_d[DL-2]) c_even = avg8(cb4, csc_q.cb);
    data_c = BLANK_DATA;
    if (de_d[DL-1]) data_c = {(odd_d[DL-1] ? pend_c : c_even), y4};
  end

  // output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_de   <= 1'b0;
      out_hs   <= 1'b0;
      out_vs   <= 1'b0;
      out_data <= 16'h0000;
    end else begin
      out_de   <= de_d[DL-1];
      out_hs   <= hs_d[DL-1];
      out_vs   <= vs_d[DL-1];
      out_data <= data_c;
    end
  end

endmodule

// File: tb/tb_hdmi_422_formatter.sv
// tb/tb_hdmi_422_formatter.sv - self-checking bench for hdmi_422_formatter
module tb_hdmi_422_formatter;

  localparam int MAXC = 12000;

  logic        clk = 1'b0;
  logic        rst, in_de, in_hs, in_vs, mode;
  logic [23:0] in_pix;
  logic        out_de, out_hs, out_vs;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  hdmi_422_formatter dut (
    .clk      (clk),
    .rst      (rst),
    .in_de    (in_de),
    .in_hs    (in_hs),
    .in_vs    (in_vs),
    .in_pix   (in_pix),
    .mode     (mode),
    .out_de   (out_de),
    .out_hs   (out_hs),
    .out_vs   (out_vs),
    .out_data (out_data)
  );

  bit          r_rst [MAXC];
  bit          r_de  [MAXC];
  bit          r_hs  [MAXC];
  bit          r_vs  [MAXC];
  bit          r_odd [MAXC];
  int          r_y   [MAXC];
  int          r_cb  [MAXC];
  int          r_cr  [MAXC];
  bit          lit_v [MAXC];
  logic [15:0] lit_d [MAXC];

  int n = 0;
  int total = 0;
  int bad = 0;
  int mq = 0;
  int pos = 0;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int avgi(int a, int b);
    return (a + b + 1) / 2;
  endfunction

  task automatic model_pix(input bit [23:0] p, input int md, output int y, output int cb, output int cr);
    int a, b, c;
    a = p[23:16];
    b = p[15:8];
    c = p[7:0];
    if (md != 0) begin
      y  = clampi(a, 16, 235);
      cb = clampi(b, 16, 240);
      cr = clampi(c, 16, 240);
    end else begin
      y  = clampi(16  + ((47*a + 157*b + 16*c + 128) >>> 8), 16, 235);
      cb = clampi(128 + ((-26*a - 86*b + 112*c + 128) >>> 8), 16, 240);
      cr = clampi(128 + ((112*a - 102*b - 10*c + 128) >>> 8), 16, 240);
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, n, act, exp);
    end
  endtask

  task automatic check_outputs();
    int e_de, e_hs, e_vs, e_d, i, c;
    bit flushed;
    if (n < 1) return;
    if (r_rst[n-1]) begin
      e_de = 0; e_hs = 0; e_vs = 0; e_d = 0;
    end else begin
      flushed = (n < 5);
      for (int k = n - 5; k <= n - 2; k++) if (k >= 0 && r_rst[k]) flushed = 1;
      if (flushed) begin
        e_de = 0; e_hs = 0; e_vs = 0; e_d = 16'h8010;
      end else begin
        i = n - 5;
        e_de = r_de[i];
        e_hs = r_hs[i];
        e_vs = r_vs[i];
        e_d  = 16'h8010;
        if (r_de[i]) begin
          if (r_odd[i]) c = avgi(r_cr[i-1], r_cr[i]);
          else if (r_de[i+1]) c = avgi(r_cb[i], r_cb[i+1]);
          else c = r_cb[i];
          e_d = c * 256 + r_y[i];
        end
      end
    end
    cmp("out_de", int'(out_de), e_de);
    cmp("out_hs", int'(out_hs), e_hs);
    cmp("out_vs", int'(out_vs), e_vs);
    cmp("out_data", int'(out_data), e_d);
    if (lit_v[n]) cmp("literal", int'(out_data), int'(lit_d[n]));
  endtask

  task automatic step(input bit r, input bit de, input bit hs, input bit vs,
                      input bit [23:0] p, input bit md, input int lit);
    bit de_e, vs_e;
    int y, cb, cr;
    @(negedge clk);
    check_outputs();
    if (n >= MAXC - 6) begin
      $display("FAIL cycle_budget cycle %0d: got %0d want < %0d", n, n, MAXC - 6);
      $fatal(1);
    end
    de_e = de & !r;
    vs_e = vs & !r;
    r_rst[n] = r;
    r_de[n]  = de_e;
    r_hs[n]  = hs;
    r_vs[n]  = vs_e;
    model_pix(p, mq, y, cb, cr);
    r_y[n] = y; r_cb[n] = cb; r_cr[n] = cr;
    if (de_e) pos = (n > 0 && r_de[n-1]) ? pos + 1 : 0;
    r_odd[n] = de_e && (pos % 2 == 1);
    if (r) mq = 0;
    else if (vs_e && !(n > 0 && r_vs[n-1])) mq = md;
    if (lit >= 0) begin
      lit_v[n+5] = 1'b1;
      lit_d[n+5] = lit[15:0];
    end
    if (r) begin
      lit_v[n+1] = 1'b1; lit_d[n+1] = 16'h0000;
      lit_v[n+2] = 1'b1; lit_d[n+2] = 16'h8010;
    end
    rst = r; in_de = de; in_hs = hs; in_vs = vs; in_pix = p; mode = md;
    n++;
  endtask

  task automatic idle(input int k, input bit md);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0, 24'h0, md, -1);
  endtask

  initial begin
    int len, gap;
    bit md;
    bit [23:0] p;
    rst = 1'b1; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_pix = '0; mode = 1'b0;

    for (int j = 0; j < 6; j++) step(1, 0, 0, 0, 24'h0, 0, -1);
    idle(4, 0);

    // white line, mode 0
    step(0, 0, 1, 0, 24'h0, 0, -1);
    for (int j = 0; j < 8; j++) step(0, 1, 0, 0, 24'hFFFFFF, 0, 16'h80EB);
    idle(4, 0);

    // red line, averaged chroma
    for (int j = 0; j < 8; j++) step(0, 1, 0, 0, 24'hFF0000, 0, (j % 2 == 0) ? 16'h663F : 16'hF03F);
    idle(4, 0);

    // switch to YCbCr input at a vsync rising edge
    step(0, 0, 0, 1, 24'h0, 1, -1);
    step(0, 0, 0, 1, 24'h0, 1, -1);
    idle(3, 1);
    for (int j = 0; j < 8; j++)
      step(0, 1, 0, 0, (j % 2 == 0) ? 24'h1000FF : 24'hEBFF00, 1, (j % 2 == 0) ? 16'h8010 : 16'h80EB);
    idle(3, 0);

    // mode input dropped mid-frame: format must not change yet
    for (int j = 0; j < 6; j++)
      step(0, 1, 0, 0, (j % 2 == 0) ? 24'h1000FF : 24'hEBFF00, 0, (j % 2 == 0) ? 16'h8010 : 16'h80EB);
    idle(3, 0);
    step(0, 0, 0, 1, 24'h0, 0, -1);
    step(0, 0, 0, 1, 24'h0, 0, -1);
    idle(3, 0);

    // odd-length black line, then next line must start on Cb
    for (int j = 0; j < 5; j++) step(0, 1, 0, 0, 24'h000000, 0, 16'h8010);
    idle(3, 0);
    for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 24'hFF0000, 0, (j % 2 == 0) ? 16'h663F : 16'hF03F);
    idle(3, 0);

    // one-clock reset in the middle of a line
    for (int j = 0; j < 3; j++) step(0, 1, 0, 0, 24'hFF0000, 0, -1);
    step(1, 1, 0, 0, 24'hFF0000, 0, -1);
    for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 24'hFF0000, 0, (j % 2 == 0) ? 16'h663F : 16'hF03F);
    idle(4, 0);

    // randomized small frames
    md = 1'b0;
    for (int f = 0; f < 8; f++) begin
      md = 1'($urandom_range(0, 1));
      step(0, 0, 0, 1, 24'h0, md, -1);
      step(0, 0, 0, 1, 24'h0, md, -1);
      for (int l = 0; l < 8; l++) begin
        step(0, 0, 1, 0, 24'h0, md, -1);
        step(0, 0, 1, 0, 24'h0, md, -1);
        gap = $urandom_range(1, 4);
        idle(gap, md);
        len = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(1, 24);
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 15) == 0) md = ~md;
          p = 24'($urandom());
          step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, 1, 0, 0, p, md, -1);
        end
      end
      idle(3, md);
    end

    idle(8, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
